// File: rtl/complement2.sv
// Two's-complement negation: a combinational result plus a registered,
// valid/ready-handshaked copy with zero/overflow flags and a one-entry skid buffer.
module complement2 #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in,
   output logic [N-1:0] out,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] out_reg,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         zero_flag,
   output logic         ovf_flag
);

   typedef struct packed {
      logic [N-1:0] data;
      logic         zero;
      logic         ovf;
   } entry_t;

   localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] ZERO    = {N{1'b0}};
   localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

   function automatic logic [N-1:0] negate(input logic [N-1:0] v);
      return (~v) + ONE;
   endfunction

   function automatic entry_t make_entry(input logic [N-1:0] v);
      entry_t e;
      e.data = negate(v);
      e.zero = (v == ZERO);
      e.ovf  = (v == MOST_NEG);
      return e;
   endfunction

   entry_t out_ent_r, out_ent_s;
   entry_t skid_ent_r, skid_ent_s;
   entry_t new_ent_s;
   logic   out_valid_r, out_valid_s;
   logic   skid_valid_r, skid_valid_s;
   logic   cap_s, drain_s;

   assign out = negate(in);

   assign cap_s   = in_valid && !skid_valid_r;
   assign drain_s = out_valid_r && out_ready;
   // The operand is masked when not captured so X on an idle bus never reaches state.
   assign new_ent_s = cap_s ? make_entry(in) : '0;

   // Next-state for the output and skid registers.
   always_comb begin
      out_ent_s    = out_ent_r;
      out_valid_s  = out_valid_r;
      skid_ent_s   = skid_ent_r;
      skid_valid_s = skid_valid_r;
      if (!out_valid_r || drain_s) begin
         if (skid_valid_r) begin
            out_ent_s    = skid_ent_r;
            out_valid_s  = 1'b1;
            skid_valid_s = 1'b0;
         end else if (cap_s) begin
            out_ent_s   = new_ent_s;
            out_valid_s = 1'b1;
         end else begin
            out_valid_s = 1'b0;
         end
      end else begin
         if (cap_s) begin
            skid_ent_s   = new_ent_s;
            skid_valid_s = 1'b1;
         end else begin
            skid_valid_s = skid_valid_r;
         end
      end
   end

   // State registers, cleared immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_ent_r    <= '0;
         out_valid_r  <= 1'b0;
         skid_ent_r   <= '0;
         skid_valid_r <= 1'b0;
      end else begin
         out_ent_r    <= out_ent_s;
         out_valid_r  <= out_valid_s;
         skid_ent_r   <= skid_ent_s;
         skid_valid_r <= skid_valid_s;
      end
   end

   assign in_ready  = !skid_valid_r;
   assign out_valid = out_valid_r;
   assign out_reg   = out_ent_r.data;
   assign zero_flag = out_ent_r.zero;
   assign ovf_flag  = out_ent_r.ovf;

endmodule

// File: tb/tb_complement2.sv
// Directed self-checking bench for complement2 (N=32): combinational path,
// reset, single transfers, backpressure with skid, idle-X isolation, streaming.
module tb_complement2;

   logic        clk;
   logic        rst;
   logic [31:0] in;
   logic [31:0] out;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_reg;
   logic        out_valid;
   logic        out_ready;
   logic        zero_flag;
   logic        ovf_flag;

   int errors = 0;
   int checks = 0;

   complement2 #(.N(32)) dut (
      .clk(clk), .rst(rst), .in(in), .out(out),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_reg(out_reg), .out_valid(out_valid), .out_ready(out_ready),
      .zero_flag(zero_flag), .ovf_flag(ovf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_comb();
      logic [31:0] vin [5]  = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005};
      logic [31:0] vexp [5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFB};
      for (int i = 0; i < 5; i++) begin
         in = vin[i];
         #1;
         checks++;
         if (out !== vexp[i]) begin
            errors++;
            $display("FAIL comb[%0d] in=%h out=%h expected=%h", i, vin[i], out, vexp[i]);
         end
      end
   endtask

   task automatic test_reset_state();
      checks++;
      if (out_valid !== 1'b0 || out_reg !== 32'h0 || zero_flag !== 1'b0 ||
          ovf_flag !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state v=%b r=%h z=%b o=%b rdy=%b expected 0/0/0/0/1",
                  out_valid, out_reg, zero_flag, ovf_flag, in_ready);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1; in_valid = 1'b1; in = 32'h8000_0000;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_reg !== 32'h8000_0000 || ovf_flag !== 1'b1 || zero_flag !== 1'b0) begin
         errors++;
         $display("FAIL single_ovf v=%b r=%h o=%b z=%b expected 1/80000000/1/0",
                  out_valid, out_reg, ovf_flag, zero_flag);
      end
      in = 32'h0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_reg !== 32'h0 || zero_flag !== 1'b1 || ovf_flag !== 1'b0) begin
         errors++;
         $display("FAIL single_zero v=%b r=%h z=%b o=%b expected 1/00000000/1/0",
                  out_valid, out_reg, zero_flag, ovf_flag);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; in = 32'd7;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_reg !== 32'hFFFF_FFF9 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first v=%b r=%h rdy=%b expected 1/fffffff9/1", out_valid, out_reg, in_ready);
      end
      in = 32'd9;
      step();
      checks++;
      if (in_ready !== 1'b0 || out_reg !== 32'hFFFF_FFF9) begin
         errors++;
         $display("FAIL bp_second rdy=%b r=%h expected 0/fffffff9", in_ready, out_reg);
      end
      in = 32'd11;
      step();
      checks++;
      if (in_ready !== 1'b0 || out_reg !== 32'hFFFF_FFF9 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold rdy=%b r=%h v=%b expected 0/fffffff9/1", in_ready, out_reg, out_valid);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_reg !== 32'hFFFF_FFF7 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_rel1 v=%b r=%h rdy=%b expected 1/fffffff7/1", out_valid, out_reg, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_reg !== 32'hFFFF_FFF5) begin
         errors++;
         $display("FAIL bp_rel2 v=%b r=%h expected 1/fffffff5", out_valid, out_reg);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_idle_x();
      out_ready = 1'b0; in_valid = 1'b1; in = 32'd3;
      step();
      in_valid = 1'b0; in = 'x;
      step();
      step();
      checks++;
      if (out_valid !== 1'b1 || out_reg !== 32'hFFFF_FFFD || zero_flag !== 1'b0 ||
          ovf_flag !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_x v=%b r=%h z=%b o=%b rdy=%b expected 1/fffffffd/0/0/1",
                  out_valid, out_reg, zero_flag, ovf_flag, in_ready);
      end
      out_ready = 1'b1; in = 32'h0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_x_drain out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in = 32'h0;
      step();
      in = 32'd4;
      step();
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_reg !== 32'h0 || zero_flag !== 1'b0 ||
          ovf_flag !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_async v=%b r=%h z=%b o=%b rdy=%b expected 0/0/0/0/1",
                  out_valid, out_reg, zero_flag, ovf_flag, in_ready);
      end
      step();
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_stale[%0d] v=%b rdy=%b expected 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_streaming();
      logic [31:0] v;
      int bad = 0;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == 10)      v = 32'h0;
         else if (i == 20) v = 32'h8000_0000;
         else if (i == 30) v = 32'hFFFF_FFFF;
         else              v = $urandom;
         in = v;
         step();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_reg !== (32'd0 - v) ||
             zero_flag !== (v == 32'h0) || ovf_flag !== (v == 32'h8000_0000)) begin
            errors++;
            bad++;
            if (bad <= 5)
               $display("FAIL stream[%0d] in=%h v=%b rdy=%b r=%h z=%b o=%b expected r=%h",
                        i, v, out_valid, in_ready, out_reg, zero_flag, ovf_flag, 32'd0 - v);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end out_valid=%b expected 0", out_valid);
      end
   endtask

   initial begin
      rst = 1'b1; in = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
      test_comb();
      step();
      test_reset_state();
      rst = 1'b0;
      step();
      test_reset_state();
      test_single();
      test_backpressure();
      test_idle_x();
      test_reset_mid();
      test_streaming();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
